// File: rtl/register_file_write_port_pkg.sv
// Shared register-file constants and types.
// Used by the write port, its decoder and the read multiplexers.
package register_file_write_port_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_COUNT  = 16;
  localparam int PC_INDEX   = 15;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_write_port_decoder.sv
// 4-to-16 one-hot decoder with enable; all zeros when disabled.
// Ports: en, addr -> sel (one-hot, at most one bit high).
module decoder_4_to_16
  import register_file_write_port_pkg::*;
(
  input  logic                 en,
  input  reg_addr_t            addr,
  output logic [REG_COUNT-1:0] sel
);

  // Gating on en first keeps an unknown addr harmless while idle.
  always_comb begin
    sel = '0;
    if (en) sel[addr] = 1'b1;
  end

endmodule

// File: rtl/register_file_write_port.sv
// Write side of the 16x32 register file; R15 also loads the next PC.
// Ports: clk, reset, wr_en/wr_addr/wr_data, pc_ld/pc_in -> reg_out, pc_out, wr_ack.
module register_file_write_port #(
  parameter int WIDTH    = register_file_write_port_pkg::WORD_W,
  parameter int NREGS    = register_file_write_port_pkg::REG_COUNT,
  parameter int PC_INDEX = register_file_write_port_pkg::PC_INDEX
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  register_file_write_port_pkg::reg_addr_t wr_addr,
  input  logic [WIDTH-1:0]                      wr_data,
  input  logic                                  pc_ld,
  input  logic [WIDTH-1:0]                      pc_in,
  output logic [NREGS*WIDTH-1:0]                reg_out,
  output logic [WIDTH-1:0]                      pc_out,
  output logic                                  wr_ack
);

  logic [NREGS-1:0]            sel;
  logic [NREGS-1:0][WIDTH-1:0] regs;

  decoder_4_to_16 u_dec (
    .en   (wr_en),
    .addr (wr_addr),
    .sel  (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs   <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      for (int i = 0; i < NREGS; i++) begin
        if (sel[i]) begin
          regs[i] <= wr_data;
        end else if (i == PC_INDEX && pc_ld) begin
          // General write to PC wins; fetch load only otherwise.
          regs[i] <= pc_in;
        end
      end
    end
  end

  // Packed array: word i lands at bits [i*WIDTH +: WIDTH].
  assign reg_out = regs;
  assign pc_out  = regs[PC_INDEX];

endmodule

// File: tb/tb_register_file_write_port.sv
// Directed self-checking bench for register_file_write_port.
// Includes a local 16-to-1 read mux to check write-to-read latency.
module tb_register_file_write_port;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         pc_ld;
  logic [31:0]  pc_in;
  logic [511:0] reg_out;
  logic [31:0]  pc_out;
  logic         wr_ack;
  logic [3:0]   rd_sel;
  logic [31:0]  mux_out;
  logic [31:0]  model [16];
  int           checks = 0;
  int           failures = 0;

  register_file_write_port dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .pc_ld   (pc_ld),
    .pc_in   (pc_in),
    .reg_out (reg_out),
    .pc_out  (pc_out),
    .wr_ack  (wr_ack)
  );

  always #5 clk = ~clk;

  assign mux_out = reg_out[rd_sel*32 +: 32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_r%0d", tag, i), reg_out[i*32 +: 32], model[i]);
    chk({tag, "_pc"}, pc_out, model[15]);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    pc_ld = 1'b0;
    pc_in = '0;
    rd_sel = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset held over an edge: everything zero.
    step();
    chk_all("reset");
    chk("reset_ack", {31'b0, wr_ack}, 32'd0);

    // Release mid-cycle, then write R3.
    reset = 1'b0;
    wr_en = 1'b1;
    wr_addr = 4'd3;
    wr_data = 32'hDEADBEEF;
    step();
    chk("r3_write", reg_out[3*32 +: 32], 32'hDEADBEEF);
    chk("r3_ack", {31'b0, wr_ack}, 32'd1);

    // Async reset between edges clears immediately.
    wr_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_r3", reg_out[3*32 +: 32], 32'd0);
    chk("async_ack", {31'b0, wr_ack}, 32'd0);

    // Writes are blocked while reset is held.
    wr_en = 1'b1;
    wr_addr = 4'd4;
    wr_data = 32'h1;
    step();
    chk_all("rst_block");
    #2;
    reset = 1'b0;
    wr_en = 1'b0;

    // Sweep every register.
    step();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_addr = 4'(i);
      wr_data = 32'h1000_0000 + 32'(i);
      step();
      model[i] = 32'h1000_0000 + 32'(i);
      chk($sformatf("sweep_ack%0d", i), {31'b0, wr_ack}, 32'd1);
    end
    chk_all("sweep");

    // Enable low: nothing written, ack drops.
    wr_en = 1'b0;
    wr_addr = 4'd5;
    wr_data = 32'hFFFFFFFF;
    step();
    chk("en_low_r5", reg_out[5*32 +: 32], 32'h10000005);
    chk("en_low_ack", {31'b0, wr_ack}, 32'd0);
    wr_addr = 4'bxxxx;
    step();
    chk_all("addr_x");

    // Dedicated PC load.
    wr_addr = 4'd0;
    pc_ld = 1'b1;
    pc_in = 32'h4;
    step();
    model[15] = 32'h4;
    chk_all("pc_ld");

    // PC load together with a write to R2.
    wr_en = 1'b1;
    wr_addr = 4'd2;
    wr_data = 32'hA;
    pc_in = 32'h6;
    step();
    model[2] = 32'hA;
    model[15] = 32'h6;
    chk_all("pc_and_r2");

    // General write to R15 beats pc_ld.
    wr_addr = 4'd15;
    wr_data = 32'hBBB;
    pc_in = 32'h8;
    step();
    model[15] = 32'hBBB;
    chk_all("pc_conflict");

    // Neither source: PC holds.
    wr_en = 1'b0;
    pc_ld = 1'b0;
    pc_in = 32'h55;
    step();
    chk_all("pc_hold");

    // Read mux sees the new R14 only after the edge.
    wr_en = 1'b1;
    wr_addr = 4'd14;
    wr_data = 32'hBBB;
    rd_sel = 4'd14;
    #1;
    chk("mux_before", mux_out, 32'h1000000E);
    step();
    model[14] = 32'hBBB;
    chk("mux_after", mux_out, 32'hBBB);

    // Same-data rewrite: no visible change, ack still high.
    step();
    chk_all("rewrite");
    chk("rewrite_ack", {31'b0, wr_ack}, 32'd1);
    wr_en = 1'b0;
    step();
    chk("ack_drop", {31'b0, wr_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
